q2_panel_ctrl: RTL and testbench

Front-panel controller for the q2 CPU. It synchronizes and debounces the four active-low panel switches and the 12-bit data switch bank, and it turns switch presses into run/stop control. It also issues deposit and increment-PC commands to the core over a valid/ack handshake. It sits between the panel pins (nsw, ndep_sw, nincp_sw, nstart_sw, nstop_sw) and the core, and owns the `run` indicator.

---
 rtl/q2_panel_ctrl.sv | 140 ++++++++++++++
 tb/tb_q2_panel_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/q2_panel_ctrl.sv
// q2 front panel: switch synchronizers, debounce, and run/stop/command FSM.
// Commands go to the core over a cmd_valid/cmd_ack handshake.
module q2_panel_ctrl #(
    parameter int DB_CYCLES = 1000,
    parameter int DB_W      = 10
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [11:0] nsw,
    input  logic        ndep_sw,
    input  logic        nincp_sw,
    input  logic        nstart_sw,
    input  logic        nstop_sw,
    input  logic        halt,
    input  logic        cmd_ack,
    output logic        run,
    output logic        cmd_valid,
    output logic        cmd_op,
    output logic [11:0] cmd_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CMD
    } state_t;

    localparam int SW_STOP  = 0;
    localparam int SW_START = 1;
    localparam int SW_INCP  = 2;
    localparam int SW_DEP   = 3;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [15:0]     sync1;
    logic [15:0]     sync2;
    logic [11:0]     nsw_sync;
    logic [3:0]      db_lvl;
    logic [3:0]      db_prev;
    logic [3:0]      press;
    logic [DB_W-1:0] db_cnt [4];

    state_t      state;
    state_t      state_nx;
    logic        op_q;
    logic        op_nx;
    logic [11:0] data_q;
    logic [11:0] data_nx;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {nsw, ndep_sw, nincp_sw, nstart_sw, nstop_sw};
            sync2 <= sync1;
        end
    end

    assign nsw_sync = sync2[15:4];

    // Any agreeing sample restarts the count, so bounces never accumulate.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            db_lvl  <= '1;
            db_prev <= '1;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            db_prev <= db_lvl;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_lvl[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign press = db_prev & ~db_lvl;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state  <= IDLE;
            op_q   <= 1'b0;
            data_q <= '0;
        end else begin
            state  <= state_nx;
            op_q   <= op_nx;
            data_q <= data_nx;
        end
    end

    always_comb begin
        state_nx = state;
        op_nx    = op_q;
        data_nx  = data_q;
        unique case (state)
            IDLE: begin
                // A stop press swallows everything below it.
                if (!press[SW_STOP]) begin
                    if (press[SW_START]) begin
                        state_nx = RUN;
                    end else if (press[SW_DEP]) begin
                        state_nx = CMD;
                        op_nx    = 1'b0;
                        data_nx  = ~nsw_sync;
                    end else if (press[SW_INCP]) begin
                        state_nx = CMD;
                        op_nx    = 1'b1;
                    end
                end
            end
            RUN: begin
                if (press[SW_STOP] || halt) begin
                    state_nx = IDLE;
                end
            end
            CMD: begin
                if (cmd_ack) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign run       = (state == RUN);
    assign busy      = (state == CMD);
    assign cmd_valid = (state == CMD);
    assign cmd_op    = op_q;
    assign cmd_data  = data_q;

endmodule

// File: tb/tb_q2_panel_ctrl.sv
// Bench for q2_panel_ctrl: scripted scenarios plus random switch traffic,
// scored against a reference model of the panel rules.
module tb_q2_panel_ctrl;

    localparam int DB = 4;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_CMD  = 2;

    logic        clk = 1'b0;
    logic        nrst = 1'b1;
    logic [11:0] nsw = '1;
    logic        ndep_sw = 1'b1;
    logic        nincp_sw = 1'b1;
    logic        nstart_sw = 1'b1;
    logic        nstop_sw = 1'b1;
    logic        halt = 1'b0;
    logic        cmd_ack = 1'b0;
    logic        run;
    logic        cmd_valid;
    logic        cmd_op;
    logic [11:0] cmd_data;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          t;
        logic [15:0] v;
    } ev_t;

    ev_t exp_q[$];

    q2_panel_ctrl #(.DB_CYCLES(DB), .DB_W(4)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .nsw       (nsw),
        .ndep_sw   (ndep_sw),
        .nincp_sw  (nincp_sw),
        .nstart_sw (nstart_sw),
        .nstop_sw  (nstop_sw),
        .halt      (halt),
        .cmd_ack   (cmd_ack),
        .run       (run),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: pins reach the debouncer two edges late; a level
    // flips once DB successive samples all disagree with it.
    logic [15:0] sq[$];
    bit          hist[4][$];
    bit          m_lvl[4];
    bit          pend[4];
    int          m_mode;
    bit          m_op;
    logic [11:0] m_data;
    logic [15:0] m_prev = '0;

    task m_reset();
        sq = '{16'hFFFF, 16'hFFFF};
        for (int j = 0; j < 4; j++) begin
            hist[j].delete();
            m_lvl[j] = 1'b1;
            pend[j] = 1'b0;
        end
        m_mode = M_IDLE;
        m_op = 1'b0;
        m_data = '0;
    endtask

    always @(posedge clk) begin
        logic [15:0] smp;
        logic [15:0] tup;
        bit          all_diff;
        cyc++;
        if (!nrst) begin
            m_reset();
        end else begin
            smp = sq.pop_front();
            sq.push_back({nsw, ndep_sw, nincp_sw, nstart_sw, nstop_sw});
            case (m_mode)
                M_IDLE: begin
                    if (pend[0]) m_mode = M_IDLE;
                    else if (pend[1]) m_mode = M_RUN;
                    else if (pend[3]) begin
                        m_mode = M_CMD;
                        m_op = 1'b0;
                        m_data = ~smp[15:4];
                    end else if (pend[2]) begin
                        m_mode = M_CMD;
                        m_op = 1'b1;
                    end
                end
                M_RUN: if (pend[0] || halt) m_mode = M_IDLE;
                default: if (cmd_ack) m_mode = M_IDLE;
            endcase
            for (int j = 0; j < 4; j++) begin
                hist[j].push_back(smp[j]);
                if (hist[j].size() > DB) void'(hist[j].pop_front());
                all_diff = (hist[j].size() == DB);
                foreach (hist[j][k]) if (hist[j][k] == m_lvl[j]) all_diff = 1'b0;
                pend[j] = all_diff && m_lvl[j];
                if (all_diff) m_lvl[j] = ~m_lvl[j];
            end
        end
        tup = {m_mode == M_RUN, m_mode == M_CMD, m_mode == M_CMD, m_op, m_data};
        if (tup !== m_prev) begin
            exp_q.push_back('{cyc, tup});
            m_prev = tup;
        end
    end

    // Monitor: every change of the output bundle must match the next model event.
    logic [15:0] last_dut = '0;
    always @(negedge clk) begin
        logic [15:0] cur;
        ev_t         e;
        cur = {run, busy, cmd_valid, cmd_op, cmd_data};
        if (cur !== last_dut) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change cyc=%0d got=%h none expected", cyc, cur);
            end else begin
                e = exp_q.pop_front();
                if (e.t != cyc || e.v !== cur) begin
                    errors++;
                    $display("FAIL event cyc=%0d got=%h expected cyc=%0d val=%h",
                             cyc, cur, e.t, e.v);
                end
            end
            last_dut = cur;
        end
    end

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_once();
        cmd_ack = 1'b1;
        tick(1);
        cmd_ack = 1'b0;
    endtask

    task automatic release_all();
        ndep_sw = 1'b1;
        nincp_sw = 1'b1;
        nstart_sw = 1'b1;
        nstop_sw = 1'b1;
    endtask

    initial begin
        #1 nrst = 1'b0;
        #1 chk("reset_outputs", {run, busy, cmd_valid, cmd_op, cmd_data}, 16'h0);
        tick(3);
        #1 nrst = 1'b1;
        tick(2);

        repeat (6) begin
            ndep_sw = 1'b0;
            tick(3);
            ndep_sw = 1'b1;
            tick(2);
        end
        tick(10);
        chk("glitch_no_cmd", {15'h0, cmd_valid}, 16'h0);

        nsw = 12'h5A3;
        ndep_sw = 1'b0;
        tick(6);
        chk("dep_not_yet", {15'h0, cmd_valid}, 16'h0);
        tick(1);
        chk("dep_valid", {busy, cmd_valid, cmd_op, 1'b0, cmd_data}, 16'hCA5C);
        tick(10);
        chk("dep_held", {busy, cmd_valid, cmd_op, 1'b0, cmd_data}, 16'hCA5C);
        ack_once();
        chk("dep_acked", {15'h0, cmd_valid}, 16'h0);
        ndep_sw = 1'b1;
        tick(10);
        ndep_sw = 1'b0;
        tick(8);
        chk("dep_again", {15'h0, cmd_valid}, 16'h1);
        ack_once();
        ndep_sw = 1'b1;
        tick(10);

        nstart_sw = 1'b0;
        tick(7);
        chk("run_on", {15'h0, run}, 16'h1);
        nstart_sw = 1'b1;
        ndep_sw = 1'b0;
        nincp_sw = 1'b0;
        tick(10);
        chk("run_ignores_cmd", {14'h0, run, cmd_valid}, 16'h2);
        release_all();
        tick(8);
        halt = 1'b1;
        tick(1);
        halt = 1'b0;
        chk("halt_stops", {15'h0, run}, 16'h0);

        nstart_sw = 1'b0;
        tick(7);
        nstart_sw = 1'b1;
        tick(8);
        nstop_sw = 1'b0;
        tick(6);
        chk("stop_not_yet", {15'h0, run}, 16'h1);
        tick(1);
        chk("stop_run_off", {15'h0, run}, 16'h0);
        nstop_sw = 1'b1;
        tick(8);
        nstart_sw = 1'b0;
        nstop_sw = 1'b0;
        tick(10);
        chk("start_stop_same", {15'h0, run}, 16'h0);
        release_all();
        tick(8);
        nsw = 12'h0F0;
        ndep_sw = 1'b0;
        nincp_sw = 1'b0;
        tick(7);
        chk("dep_over_incp", {cmd_valid, cmd_op, 2'b0, cmd_data}, 16'h8F0F);
        ack_once();
        release_all();
        tick(8);

        nincp_sw = 1'b0;
        tick(7);
        chk("incp_valid", {14'h0, cmd_valid, cmd_op}, 16'h3);
        nincp_sw = 1'b1;
        tick(6);
        nstart_sw = 1'b0;
        tick(8);
        nstart_sw = 1'b1;
        tick(6);
        nstop_sw = 1'b0;
        tick(8);
        nstop_sw = 1'b1;
        tick(6);
        chk("cmd_blocks", {14'h0, run, cmd_valid}, 16'h1);
        ack_once();
        tick(2);
        chk("after_block", {13'h0, run, busy, cmd_valid}, 16'h0);

        ndep_sw = 1'b0;
        tick(8);
        #1 nrst = 1'b0;
        #1 chk("async_reset", {run, busy, cmd_valid, cmd_op, cmd_data}, 16'h0);
        ndep_sw = 1'b1;
        nstart_sw = 1'b0;
        tick(3);
        #1 nrst = 1'b1;
        tick(6);
        chk("held_not_yet", {15'h0, run}, 16'h0);
        tick(1);
        chk("held_run", {15'h0, run}, 16'h1);
        nstart_sw = 1'b1;
        tick(6);
        nstop_sw = 1'b0;
        tick(8);
        nstop_sw = 1'b1;
        tick(8);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            nrst = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 5) == 0) ndep_sw = ~ndep_sw;
            if ($urandom_range(0, 5) == 0) nincp_sw = ~nincp_sw;
            if ($urandom_range(0, 5) == 0) nstart_sw = ~nstart_sw;
            if ($urandom_range(0, 5) == 0) nstop_sw = ~nstop_sw;
            if ($urandom_range(0, 7) == 0) nsw = 12'($urandom);
            halt = ($urandom_range(0, 15) == 0);
            cmd_ack = ($urandom_range(0, 2) == 0);
        end
        @(negedge clk);
        #1;
        nrst = 1'b1;
        release_all();
        halt = 1'b0;
        cmd_ack = 1'b1;
        tick(20);
        #2;
        chk("scoreboard_drained", 16'(exp_q.size()), 16'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
